// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: oversampled SPI slave register file with read-back, bit-set, clear-all and frame-error reporting.
// All logic runs on block_clk_i; the SPI pins are only sampled through synchronisers.
module spi_regfile_slave #(
  parameter int NUM_REGS    = 10,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int CMD_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       block_clk_i,
  input  logic                       rst_low_i,
  input  logic                       spi_sclk_i,
  input  logic                       spi_ss_i,
  input  logic                       spi_mosi_i,
  output logic                       spi_miso_o,
  output logic [NUM_REGS*DATA_W-1:0] reg_data_o,
  output logic                       wr_pulse_o,
  output logic [ADDR_W-1:0]          wr_addr_o,
  output logic                       frame_err_o
);
  localparam int FRAME_W = CMD_W + ADDR_W + DATA_W;
  localparam int HDR_W   = CMD_W + ADDR_W;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CMD_W-1:0] CMD_WRITE = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(2);
  localparam logic [CMD_W-1:0] CMD_SET   = CMD_W'(3);
  localparam logic [CMD_W-1:0] CMD_CLEAR = CMD_W'(4);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-2:0]     rx_q, rx_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   rd_active_q, rd_active_d;
  logic                   miso_q, miso_d;
  logic                   wr_pulse_q, wr_pulse_d, frame_err_q, frame_err_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];

  logic               sclk_s, ss_s, mosi_s, rise, fall, ss_rise, commit, hdr_done;
  logic               in_range, hdr_in_range, is_write, is_set, is_clear, is_read;
  logic [FRAME_W-1:0] frame;
  logic [CMD_W-1:0]   cmd, hdr_cmd;
  logic [ADDR_W-1:0]  addr, hdr_addr;
  logic [DATA_W-1:0]  data, rd_val;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_i};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    ss_s         = ss_sync_q[SYNC_STAGES-1];
    mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    sclk_prev_d  = sclk_s;
    ss_prev_d    = ss_s;
    rise         = ~ss_s & sclk_s & ~sclk_prev_q;
    fall         = ~ss_s & ~sclk_s & sclk_prev_q;
    ss_rise      = ss_s & ~ss_prev_q;
    frame        = {rx_q, mosi_s};
    commit       = rise && cnt_q == CNT_W'(FRAME_W-1);
    hdr_done     = rise && cnt_q == CNT_W'(HDR_W-1);
    cmd          = frame[FRAME_W-1 -: CMD_W];
    addr         = frame[DATA_W +: ADDR_W];
    data         = frame[DATA_W-1:0];
    // at the header-complete rise only the low HDR_W bits belong to this frame
    hdr_cmd      = frame[HDR_W-1 -: CMD_W];
    hdr_addr     = frame[ADDR_W-1:0];
    in_range     = int'(addr) < NUM_REGS;
    hdr_in_range = int'(hdr_addr) < NUM_REGS;
    rd_val       = hdr_in_range ? regs_q[hdr_addr] : '1;
    is_write     = cmd == CMD_WRITE;
    is_set       = cmd == CMD_SET;
    is_clear     = cmd == CMD_CLEAR;
    is_read      = cmd == CMD_READ;
    rx_d         = rise ? frame[FRAME_W-2:0] : rx_q;
    cnt_d        = ss_rise ? '0 : rise ? (commit ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    rd_active_d  = hdr_done ? hdr_cmd == CMD_READ : (commit || ss_rise) ? 1'b0 : rd_active_q;
    tx_d         = hdr_done ? rd_val : (fall && rd_active_q) ? {tx_q[DATA_W-2:0], 1'b1} : tx_q;
    miso_d       = (commit || ss_rise) ? 1'b1 : (fall && rd_active_q) ? tx_q[DATA_W-1] : miso_q;
    wr_pulse_d   = commit && (is_clear || ((is_write || is_set) && in_range));
    wr_addr_d    = (commit && is_clear) ? '0 :
                   (commit && (is_write || is_set) && in_range) ? addr : wr_addr_q;
    frame_err_d  = commit ? (((is_write || is_set || is_read) && !in_range) || cmd > CMD_CLEAR)
                          : (ss_rise && cnt_q != '0);
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (commit && is_clear) regs_d[i] = '0;
      else if (commit && in_range && int'(addr) == i && is_write) regs_d[i] = data;
      else if (commit && in_range && int'(addr) == i && is_set) regs_d[i] = regs_q[i] | data;
    end
  end

  always_ff @(posedge block_clk_i or negedge rst_low_i) begin
    if (!rst_low_i) begin
      sclk_sync_q <= '1;
      ss_sync_q   <= '1;
      mosi_sync_q <= '1;
      sclk_prev_q <= 1'b1;
      ss_prev_q   <= 1'b1;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rd_active_q <= 1'b0;
      miso_q      <= 1'b1;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      frame_err_q <= 1'b0;
      regs_q      <= '{default: '0};
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rd_active_q <= rd_active_d;
      miso_q      <= miso_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_out
    assign reg_data_o[n*DATA_W +: DATA_W] = regs_q[n];
  end

  assign spi_miso_o  = miso_q;
  assign wr_pulse_o  = wr_pulse_q;
  assign wr_addr_o   = wr_addr_q;
  assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_spi_regfile_slave.sv
// tb_spi_regfile_slave: directed scenario bench for spi_regfile_slave (default parameters).
module tb_spi_regfile_slave;
  logic        block_clk_i = 1'b0;
  logic        rst_low_i   = 1'b0;
  logic        spi_sclk_i  = 1'b1;
  logic        spi_ss_i    = 1'b1;
  logic        spi_mosi_i  = 1'b1;
  logic        spi_miso_o;
  logic [79:0] reg_data_o;
  logic        wr_pulse_o;
  logic [3:0]  wr_addr_o;
  logic        frame_err_o;

  int pass_cnt  = 0;
  int check_cnt = 0;
  int pulse_cnt = 0;
  int err_cnt   = 0;
  logic [79:0] exp_data = '0;

  spi_regfile_slave dut (
    .block_clk_i(block_clk_i), .rst_low_i(rst_low_i), .spi_sclk_i(spi_sclk_i),
    .spi_ss_i(spi_ss_i), .spi_mosi_i(spi_mosi_i), .spi_miso_o(spi_miso_o),
    .reg_data_o(reg_data_o), .wr_pulse_o(wr_pulse_o), .wr_addr_o(wr_addr_o),
    .frame_err_o(frame_err_o)
  );

  always #5 block_clk_i = ~block_clk_i;

  always @(negedge block_clk_i) begin
    if (wr_pulse_o) pulse_cnt <= pulse_cnt + 1;
    if (frame_err_o) err_cnt <= err_cnt + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge block_clk_i);
  endtask

  task automatic ss_low();
    spi_ss_i = 1'b0;
    wait_clks(4);
  endtask

  task automatic ss_high();
    spi_ss_i = 1'b1;
    wait_clks(6);
  endtask

  // sends the top n bits of w MSB first; rd collects MISO as sampled just before rises 9..16
  task automatic spi_frame(input logic [15:0] w, input int n, output logic [7:0] rd);
    rd = '0;
    for (int i = 15; i >= 16 - n; i--) begin
      spi_sclk_i = 1'b0;
      spi_mosi_i = w[i];
      wait_clks(4);
      if (i < 8) rd[i] = spi_miso_o;
      spi_sclk_i = 1'b1;
      wait_clks(4);
    end
  endtask

  task automatic one_frame(input logic [15:0] w, output logic [7:0] rd);
    ss_low();
    spi_frame(w, 16, rd);
    ss_high();
  endtask

  task automatic test_reset();
    rst_low_i = 1'b0;
    wait_clks(3);
    check_cnt++; if (reg_data_o !== 80'h0) $display("FAIL reset_regs: got %h want 0", reg_data_o); else pass_cnt++;
    check_cnt++; if (spi_miso_o !== 1'b1) $display("FAIL reset_miso: got %b want 1", spi_miso_o); else pass_cnt++;
    check_cnt++; if (wr_pulse_o !== 1'b0) $display("FAIL reset_pulse: got %b want 0", wr_pulse_o); else pass_cnt++;
    check_cnt++; if (wr_addr_o !== 4'h0) $display("FAIL reset_addr: got %h want 0", wr_addr_o); else pass_cnt++;
    check_cnt++; if (frame_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err_o); else pass_cnt++;
    rst_low_i = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_write();
    int p0, e0;
    logic [7:0] rd;
    p0 = pulse_cnt; e0 = err_cnt;
    ss_low();
    spi_frame(16'h13A5, 16, rd);
    exp_data[3*8 +: 8] = 8'hA5;
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL write_latency: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
    ss_high();
    check_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL write_pulses: got %0d want 1", pulse_cnt - p0); else pass_cnt++;
    check_cnt++; if (wr_addr_o !== 4'h3) $display("FAIL write_addr: got %h want 3", wr_addr_o); else pass_cnt++;
    check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL write_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_set_read();
    int p0, e0;
    logic [7:0] rd;
    one_frame(16'h150F, rd);
    one_frame(16'h35F0, rd);
    exp_data[5*8 +: 8] = 8'hFF;
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL set_regs: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
    check_cnt++; if (wr_addr_o !== 4'h5) $display("FAIL set_addr: got %h want 5", wr_addr_o); else pass_cnt++;
    p0 = pulse_cnt; e0 = err_cnt;
    one_frame(16'h2500, rd);
    check_cnt++; if (rd !== 8'hFF) $display("FAIL read_reg5: got %h want ff", rd); else pass_cnt++;
    one_frame(16'h2300, rd);
    check_cnt++; if (rd !== 8'hA5) $display("FAIL read_reg3: got %h want a5", rd); else pass_cnt++;
    check_cnt++; if (pulse_cnt - p0 !== 0) $display("FAIL read_pulses: got %0d want 0", pulse_cnt - p0); else pass_cnt++;
    check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL read_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
    check_cnt++; if (spi_miso_o !== 1'b1) $display("FAIL read_miso_idle: got %b want 1", spi_miso_o); else pass_cnt++;
    one_frame(16'h2C00, rd);
    check_cnt++; if (rd !== 8'hFF) $display("FAIL read_oor_data: got %h want ff", rd); else pass_cnt++;
    check_cnt++; if (err_cnt - e0 !== 1) $display("FAIL read_oor_err: got %0d want 1", err_cnt - e0); else pass_cnt++;
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL read_regs: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int p0, e0;
    logic [7:0] rd;
    p0 = pulse_cnt; e0 = err_cnt;
    ss_low();
    spi_frame(16'h1111, 16, rd);
    spi_frame(16'h1222, 16, rd);
    ss_high();
    exp_data[1*8 +: 8] = 8'h11;
    exp_data[2*8 +: 8] = 8'h22;
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL b2b_regs: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
    check_cnt++; if (pulse_cnt - p0 !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - p0); else pass_cnt++;
    check_cnt++; if (wr_addr_o !== 4'h2) $display("FAIL b2b_addr: got %h want 2", wr_addr_o); else pass_cnt++;
    check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
  endtask

  task automatic test_truncated();
    int p0, e0;
    logic [7:0] rd;
    p0 = pulse_cnt; e0 = err_cnt;
    ss_low();
    spi_frame(16'h1477, 9, rd);
    ss_high();
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL trunc_regs: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
    check_cnt++; if (err_cnt - e0 !== 1) $display("FAIL trunc_err: got %0d want 1", err_cnt - e0); else pass_cnt++;
    check_cnt++; if (pulse_cnt - p0 !== 0) $display("FAIL trunc_pulses: got %0d want 0", pulse_cnt - p0); else pass_cnt++;
    one_frame(16'h1477, rd);
    exp_data[4*8 +: 8] = 8'h77;
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL trunc_recover: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
  endtask

  task automatic test_bad_and_clear();
    int p0, e0;
    logic [7:0] rd;
    p0 = pulse_cnt; e0 = err_cnt;
    one_frame(16'h1C55, rd);
    check_cnt++; if (err_cnt - e0 !== 1) $display("FAIL oor_write_err: got %0d want 1", err_cnt - e0); else pass_cnt++;
    one_frame(16'h7155, rd);
    check_cnt++; if (err_cnt - e0 !== 2) $display("FAIL bad_cmd_err: got %0d want 2", err_cnt - e0); else pass_cnt++;
    one_frame(16'h0155, rd);
    check_cnt++; if (err_cnt - e0 !== 2) $display("FAIL nop_err: got %0d want 2", err_cnt - e0); else pass_cnt++;
    check_cnt++; if (reg_data_o !== exp_data) $display("FAIL bad_regs: got %h want %h", reg_data_o, exp_data); else pass_cnt++;
    check_cnt++; if (pulse_cnt - p0 !== 0) $display("FAIL bad_pulses: got %0d want 0", pulse_cnt - p0); else pass_cnt++;
    one_frame(16'h4ABC, rd);
    exp_data = '0;
    check_cnt++; if (reg_data_o !== 80'h0) $display("FAIL clear_regs: got %h want 0", reg_data_o); else pass_cnt++;
    check_cnt++; if (wr_addr_o !== 4'h0) $display("FAIL clear_addr: got %h want 0", wr_addr_o); else pass_cnt++;
    check_cnt++; if (pulse_cnt - p0 !== 1) $display("FAIL clear_pulses: got %0d want 1", pulse_cnt - p0); else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int e0;
    logic [7:0] rd;
    one_frame(16'h1001, rd);
    check_cnt++; if (reg_data_o !== 80'h01) $display("FAIL pre_rst_regs: got %h want 01", reg_data_o); else pass_cnt++;
    ss_low();
    spi_frame(16'h1699, 6, rd);
    rst_low_i = 1'b0;
    wait_clks(1);
    rst_low_i = 1'b1;
    check_cnt++; if (reg_data_o !== 80'h0) $display("FAIL midrst_regs: got %h want 0", reg_data_o); else pass_cnt++;
    check_cnt++; if (spi_miso_o !== 1'b1) $display("FAIL midrst_miso: got %b want 1", spi_miso_o); else pass_cnt++;
    e0 = err_cnt;
    ss_high();
    check_cnt++; if (err_cnt - e0 !== 0) $display("FAIL midrst_err: got %0d want 0", err_cnt - e0); else pass_cnt++;
    one_frame(16'h1699, rd);
    check_cnt++; if (reg_data_o !== 80'h99_0000_0000_0000) $display("FAIL midrst_next: got %h want 99000000000000", reg_data_o); else pass_cnt++;
    check_cnt++; if (wr_addr_o !== 4'h6) $display("FAIL midrst_addr: got %h want 6", wr_addr_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_read();
    test_back_to_back();
    test_truncated();
    test_bad_and_clear();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
